mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous data memory between the processor's load/store path (`cpu_*`) and a second bus master (`ext_*`, the program/data loader or debug port). It sits between both masters and the data memory inside `top`.
- Grants memory ownership with a registered request/grant handshake.
- Bounds each ownership period with a burst limit.
- Steers one-cycle-latency read data back to the master that issued the read.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_if.sv | 25 ++
 rtl/mem_arb_fsm.sv | 105 ++++++++++
 rtl/mem_arbiter.sv | 74 +++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the two-master data-memory arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; default is fixed CPU priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_EXT = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        EXT = 1'b1
    } owner_t;

    // A single-transfer burst limit still needs a one-bit counter.
    function automatic int burst_cnt_w(input int max_burst);
        int w;
        w = $clog2(max_burst);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Per-master request/grant channel into the arbiter; the arbiter takes the slave side.
interface mem_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arb_fsm.sv
// Ownership FSM with burst counter and last-owner tracking.
// MEM_ARB_RR_EN: round-robin tie-break and burst limit on both masters; otherwise CPU-priority.
module mem_arb_fsm
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ext_req,
    output logic cpu_gnt,
    output logic ext_gnt,
    output logic cpu_xfer,
    output logic ext_xfer
);

    localparam int               CNT_W   = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

`ifdef MEM_ARB_RR_EN
    localparam bit CPU_LIMITED = 1'b1;
`else
    localparam bit CPU_LIMITED = 1'b0;
`endif

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_t           last_owner_q, last_owner_d;
    logic             cnt_sat;
    logic             tie_to_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= EXT;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;

        cpu_gnt  = (state_q == OWN_CPU);
        ext_gnt  = (state_q == OWN_EXT);
        cpu_xfer = cpu_gnt && cpu_req;
        ext_xfer = ext_gnt && ext_req;
        cnt_sat  = (cnt_q == CNT_MAX);

`ifdef MEM_ARB_RR_EN
        tie_to_ext = (last_owner_q == CPU);
`else
        tie_to_ext = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (cpu_req && ext_req) begin
                    state_d = tie_to_ext ? OWN_EXT : OWN_CPU;
                end else if (cpu_req) begin
                    state_d = OWN_CPU;
                end else if (ext_req) begin
                    state_d = OWN_EXT;
                end
            end
            OWN_CPU: begin
                if (!cpu_req) begin
                    state_d = ext_req ? OWN_EXT : IDLE;
                end else if (CPU_LIMITED && cnt_sat && ext_req) begin
                    state_d = OWN_EXT;
                end
            end
            OWN_EXT: begin
                if (!ext_req) begin
                    state_d = cpu_req ? OWN_CPU : IDLE;
                end else if (cnt_sat && cpu_req) begin
                    state_d = OWN_CPU;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any change of ownership (including release to IDLE) starts a fresh burst.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((cpu_xfer || ext_xfer) && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d == OWN_CPU && state_q != OWN_CPU) begin
            last_owner_d = CPU;
        end else if (state_d == OWN_EXT && state_q != OWN_EXT) begin
            last_owner_d = EXT;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous data-memory port between the CPU load/store path and an external master.
// MEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_arb_if.slave          cpu,
    mem_arb_if.slave          ext,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic cpu_gnt, ext_gnt;
    logic cpu_xfer, ext_xfer;
    logic rd_pend_cpu_q, rd_pend_cpu_d;
    logic rd_pend_ext_q, rd_pend_ext_d;

    mem_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu.req),
        .ext_req  (ext.req),
        .cpu_gnt  (cpu_gnt),
        .ext_gnt  (ext_gnt),
        .cpu_xfer (cpu_xfer),
        .ext_xfer (ext_xfer)
    );

    always_comb begin
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rd_pend_cpu_d = cpu_xfer && !cpu.we;
        rd_pend_ext_d = ext_xfer && !ext.we;

        if (cpu_xfer) begin
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (ext_xfer) begin
            mem_we    = ext.we;
            mem_addr  = ext.addr;
            mem_wdata = ext.wdata;
        end
    end

    // Read return is tagged by issuer, so a read in the last owned cycle survives a handoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_cpu_q <= 1'b0;
            rd_pend_ext_q <= 1'b0;
        end else begin
            rd_pend_cpu_q <= rd_pend_cpu_d;
            rd_pend_ext_q <= rd_pend_ext_d;
        end
    end

    assign cpu.gnt    = cpu_gnt;
    assign ext.gnt    = ext_gnt;
    assign cpu.rvalid = rd_pend_cpu_q;
    assign ext.rvalid = rd_pend_ext_q;
    assign cpu.rdata  = rd_pend_cpu_q ? mem_rdata : '0;
    assign ext.rdata  = rd_pend_ext_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_arr [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpu_if ();
    mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ext_if ();

    mem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_if),
        .ext       (ext_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem_arr[mem_addr[7:2]];
    end

    task automatic drop_all();
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        ext_if.req = 1'b0; ext_if.we = 1'b0; ext_if.addr = '0; ext_if.wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drop_all();
        cpu_if.req = 1'b1;
        #20;
        checks++; if (cpu_if.gnt !== 1'b0) begin failures++; $display("FAIL reset_cpu_gnt: got %0b want 0", cpu_if.gnt); end
        checks++; if (ext_if.gnt !== 1'b0) begin failures++; $display("FAIL reset_ext_gnt: got %0b want 0", ext_if.gnt); end
        checks++; if (cpu_if.rvalid !== 1'b0 || ext_if.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %0b/%0b want 0/0", cpu_if.rvalid, ext_if.rvalid); end
        checks++; if (cpu_if.rdata !== '0 || ext_if.rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %0h/%0h want 0/0", cpu_if.rdata, ext_if.rdata); end
        #2 reset = 1'b1;
        #2;
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_idle: got we=%0b addr=%0h wdata=%0h want 0", mem_we, mem_addr, mem_wdata); end
        checks++; if (cpu_if.gnt !== 1'b0) begin failures++; $display("FAIL release_pre_edge_gnt: got %0b want 0", cpu_if.gnt); end
        @(posedge clk); #1;
        checks++; if (cpu_if.gnt !== 1'b1) begin failures++; $display("FAIL first_edge_cpu_gnt: got %0b want 1", cpu_if.gnt); end
        cpu_if.req = 1'b0;
    endtask

    task automatic test_cpu_write();
        @(posedge clk); #1;
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 32'd84; cpu_if.wdata = 32'd7;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_idle_cycle_we: got %0b want 0", mem_we); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd84 || mem_wdata !== 32'd7) begin failures++; $display("FAIL wr_xfer: got we=%0b addr=%0d wdata=%0d want 1/84/7", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        cpu_if.req = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || cpu_if.gnt !== 1'b1) begin failures++; $display("FAIL wr_drop_cycle: got we=%0b gnt=%0b want 0/1", mem_we, cpu_if.gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_if.gnt !== 1'b0 || cpu_if.rvalid !== 1'b0) begin failures++; $display("FAIL wr_back_idle: got gnt=%0b rvalid=%0b want 0/0", cpu_if.gnt, cpu_if.rvalid); end
    endtask

    task automatic test_ext_read();
        @(posedge clk); #1;
        ext_if.req = 1'b1; ext_if.we = 1'b1; ext_if.addr = 32'd80; ext_if.wdata = 32'h5;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_if.gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd80) begin failures++; $display("FAIL ext_wr_xfer: got gnt=%0b we=%0b addr=%0d want 1/1/80", ext_if.gnt, mem_we, mem_addr); end
        @(posedge clk); #1;
        ext_if.we = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'd80 || ext_if.rvalid !== 1'b0) begin failures++; $display("FAIL ext_rd_issue: got we=%0b addr=%0d rvalid=%0b want 0/80/0", mem_we, mem_addr, ext_if.rvalid); end
        @(posedge clk); #1;
        ext_if.req = 1'b0;
        @(negedge clk);
        checks++; if (ext_if.rvalid !== 1'b1 || ext_if.rdata !== 32'h5) begin failures++; $display("FAIL ext_rd_return: got rvalid=%0b rdata=%0h want 1/5", ext_if.rvalid, ext_if.rdata); end
        checks++; if (cpu_if.rvalid !== 1'b0 || cpu_if.rdata !== '0) begin failures++; $display("FAIL ext_rd_cpu_quiet: got rvalid=%0b rdata=%0h want 0/0", cpu_if.rvalid, cpu_if.rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_if.rvalid !== 1'b0 || ext_if.rdata !== '0) begin failures++; $display("FAIL ext_rd_pulse_end: got rvalid=%0b rdata=%0h want 0/0", ext_if.rvalid, ext_if.rdata); end
    endtask

    // Source codes in the traces: 0 = no transfer, 1 = CPU (addr 4), 2 = EXT (addr 8).
    task automatic test_contention();
        int exp_src [12];
        int src;
        for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_src[k] = ((k / 4) % 2 == 0) ? 1 : 2;
`else
            exp_src[k] = 1;
`endif
        end
        @(posedge clk); #1;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'd4;
        ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 32'd8;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            src = (mem_addr == 32'd4) ? 1 : (mem_addr == 32'd8) ? 2 : 0;
            checks++; if (src !== exp_src[k]) begin failures++; $display("FAIL contend_src[%0d]: got %0d want %0d", k, src, exp_src[k]); end
            checks++; if (cpu_if.rvalid !== (k > 0 && exp_src[k-1] == 1)) begin failures++; $display("FAIL contend_cpu_rvalid[%0d]: got %0b want %0b", k, cpu_if.rvalid, (k > 0 && exp_src[k-1] == 1)); end
            checks++; if (ext_if.rvalid !== (k > 0 && exp_src[k-1] == 2)) begin failures++; $display("FAIL contend_ext_rvalid[%0d]: got %0b want %0b", k, ext_if.rvalid, (k > 0 && exp_src[k-1] == 2)); end
        end
`ifndef MEM_ARB_RR_EN
        @(posedge clk); #1;
        cpu_if.req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_if.gnt !== 1'b1 || ext_if.gnt !== 1'b0 || mem_addr !== '0) begin failures++; $display("FAIL fixed_drop_cycle: got cgnt=%0b egnt=%0b addr=%0d want 1/0/0", cpu_if.gnt, ext_if.gnt, mem_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_if.gnt !== 1'b1 || mem_addr !== 32'd8) begin failures++; $display("FAIL fixed_ext_after_drop: got egnt=%0b addr=%0d want 1/8", ext_if.gnt, mem_addr); end
`endif
        @(posedge clk); #1;
        drop_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ext_burst_limit();
        int exp_src [8];
        int src;
        for (int k = 0; k < 8; k++) exp_src[k] = (k < 4) ? 2 : 1;
        @(posedge clk); #1;
        ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 32'd8;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'd4;
            end
            @(negedge clk);
            src = (mem_addr == 32'd4) ? 1 : (mem_addr == 32'd8) ? 2 : 0;
            checks++; if (src !== exp_src[k]) begin failures++; $display("FAIL ext_limit_src[%0d]: got %0d want %0d", k, src, exp_src[k]); end
            checks++; if (ext_if.rvalid !== (k > 0 && exp_src[k-1] == 2)) begin failures++; $display("FAIL ext_limit_ext_rvalid[%0d]: got %0b want %0b", k, ext_if.rvalid, (k > 0 && exp_src[k-1] == 2)); end
            checks++; if (cpu_if.rvalid !== (k > 0 && exp_src[k-1] == 1)) begin failures++; $display("FAIL ext_limit_cpu_rvalid[%0d]: got %0b want %0b", k, cpu_if.rvalid, (k > 0 && exp_src[k-1] == 1)); end
        end
        @(posedge clk); #1;
        drop_all();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 32'd12; cpu_if.wdata = 32'h33;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd12) begin failures++; $display("FAIL mid_wr_xfer: got we=%0b addr=%0d want 1/12", mem_we, mem_addr); end
        @(posedge clk); #1;
        cpu_if.we = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (cpu_if.gnt !== 1'b0 || ext_if.gnt !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt: got %0b/%0b want 0/0", cpu_if.gnt, ext_if.gnt); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0) begin failures++; $display("FAIL mid_rst_mem: got we=%0b addr=%0d want 0/0", mem_we, mem_addr); end
        cpu_if.req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (cpu_if.rvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_rvalid[%0d]: got %0b want 0", k, cpu_if.rvalid); end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_if.req = 1'b1; cpu_if.addr = 32'd4;
        ext_if.req = 1'b1; ext_if.we = 1'b0; ext_if.addr = 32'd12;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_if.gnt !== 1'b1 || ext_if.gnt !== 1'b0 || cpu_if.rvalid !== 1'b0) begin failures++; $display("FAIL post_rst_tie: got cgnt=%0b egnt=%0b crv=%0b want 1/0/0", cpu_if.gnt, ext_if.gnt, cpu_if.rvalid); end
        @(posedge clk); #1;
        cpu_if.req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ext_if.gnt !== 1'b1 || mem_addr !== 32'd12) begin failures++; $display("FAIL post_rst_ext_rd: got gnt=%0b addr=%0d want 1/12", ext_if.gnt, mem_addr); end
        @(posedge clk); #1;
        ext_if.req = 1'b0;
        @(negedge clk);
        checks++; if (ext_if.rvalid !== 1'b1 || ext_if.rdata !== 32'h33) begin failures++; $display("FAIL write_survives_reset: got rvalid=%0b rdata=%0h want 1/33", ext_if.rvalid, ext_if.rdata); end
        @(posedge clk); #1;
        drop_all();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_ext_read();
        test_contention();
        test_ext_burst_limit();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
